// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser for the VGA framebuffer path: outline, filled disc or
// full-screen clear, streamed as one clipped pixel per plot/plot_ready handshake.
module circle_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    input  logic [R_W-1:0] radius,
    input  logic [2:0]     colour_in,
    input  logic           plot_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done
);
    localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
    localparam int CW   = ((XY_W > R_W) ? XY_W : R_W) + 2;
    localparam logic signed [CW-1:0] XMAX = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] YMAX = CW'(SCREEN_H - 1);
    localparam logic signed [CW-1:0] ONE  = CW'(1);
    localparam logic signed [CW-1:0] ZERO = CW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_INIT  = 3'd2,
        S_OCT   = 3'd3,
        S_SPAN  = 3'd4,
        S_STEP  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    function automatic logic on_x(input logic signed [CW-1:0] v);
        return !v[CW-1] && (v <= XMAX);
    endfunction

    function automatic logic on_y(input logic signed [CW-1:0] v);
        return !v[CW-1] && (v <= YMAX);
    endfunction

    state_t               state_r, state_nx_s;
    logic [1:0]           mode_r;
    logic [X_W-1:0]       cx_r;
    logic [Y_W-1:0]       cy_r;
    logic [R_W-1:0]       rad_r;
    logic [2:0]           col_r;
    logic signed [CW-1:0] ox_r, oy_r, sx_r, sy_r;
    logic signed [31:0]   crit_r;
    logic [2:0]           idx_r;
    logic [1:0]           seg_r;
    logic                 span_act_r, pass_done_r;
    logic [X_W-1:0]       x_r;
    logic [Y_W-1:0]       y_r;
    logic [2:0]           colour_r;
    logic                 plot_r, busy_r, done_r;

    logic signed [CW-1:0] cx_e_s, cy_e_s, cand_x_s, cand_y_s;
    logic signed [CW-1:0] row_s, xl_s, xr_s, clamp_l_s, clamp_r_s;
    logic signed [CW-1:0] oy_inc_s, ox_dec_s, ox_nx_s;
    logic signed [31:0]   oy_inc_e_s, ox_dec_e_s, rad_e_s, crit_nx_s;
    logic                 slot_free_s, cand_on_s, span_ok_s, crit_pos_s, loop_ok_s, fill_s;
    logic                 load_s, clr_adv_s, oct_adv_s, span_adv_s, pass_exit_s;
    logic                 busy_nx_s, done_nx_s;
    logic [X_W-1:0]       pix_x_s;
    logic [Y_W-1:0]       pix_y_s;

    assign cx_e_s      = {{(CW-X_W){1'b0}}, cx_r};
    assign cy_e_s      = {{(CW-Y_W){1'b0}}, cy_r};
    assign rad_e_s     = {{(32-R_W){1'b0}}, rad_r};
    assign fill_s      = (mode_r == 2'd1);
    assign slot_free_s = !plot_r || plot_ready;
    assign pass_exit_s = pass_done_r && slot_free_s;

    // Midpoint step arithmetic: next oy/ox/crit and the loop guard on the new values.
    assign oy_inc_s    = oy_r + ONE;
    assign ox_dec_s    = ox_r - ONE;
    assign oy_inc_e_s  = {{(32-CW){oy_inc_s[CW-1]}}, oy_inc_s};
    assign ox_dec_e_s  = {{(32-CW){ox_dec_s[CW-1]}}, ox_dec_s};
    assign crit_pos_s  = (crit_r > 32'sd0);
    assign ox_nx_s     = crit_pos_s ? ox_dec_s : ox_r;
    assign crit_nx_s   = crit_pos_s ? (crit_r + (oy_inc_e_s - ox_dec_e_s) * 32'sd2 + 32'sd1)
                                    : (crit_r + oy_inc_e_s * 32'sd2 + 32'sd1);
    assign loop_ok_s   = (oy_inc_s <= ox_nx_s);

    // Octant candidate point selected by idx_r.
    always_comb begin
        cand_x_s = cx_e_s;
        cand_y_s = cy_e_s;
        case (idx_r)
            3'd0: begin cand_x_s = cx_e_s + ox_r; cand_y_s = cy_e_s + oy_r; end
            3'd1: begin cand_x_s = cx_e_s + oy_r; cand_y_s = cy_e_s + ox_r; end
            3'd2: begin cand_x_s = cx_e_s - ox_r; cand_y_s = cy_e_s + oy_r; end
            3'd3: begin cand_x_s = cx_e_s - oy_r; cand_y_s = cy_e_s + ox_r; end
            3'd4: begin cand_x_s = cx_e_s - ox_r; cand_y_s = cy_e_s - oy_r; end
            3'd5: begin cand_x_s = cx_e_s - oy_r; cand_y_s = cy_e_s - ox_r; end
            3'd6: begin cand_x_s = cx_e_s + ox_r; cand_y_s = cy_e_s - oy_r; end
            3'd7: begin cand_x_s = cx_e_s + oy_r; cand_y_s = cy_e_s - ox_r; end
            default: begin cand_x_s = cx_e_s; cand_y_s = cy_e_s; end
        endcase
    end

    assign cand_on_s = on_x(cand_x_s) && on_y(cand_y_s);

    // Fill span geometry selected by seg_r, with endpoints clamped to the screen.
    always_comb begin
        row_s = cy_e_s;
        xl_s  = cx_e_s;
        xr_s  = cx_e_s;
        case (seg_r)
            2'd0: begin row_s = cy_e_s + oy_r; xl_s = cx_e_s - ox_r; xr_s = cx_e_s + ox_r; end
            2'd1: begin row_s = cy_e_s - oy_r; xl_s = cx_e_s - ox_r; xr_s = cx_e_s + ox_r; end
            2'd2: begin row_s = cy_e_s + ox_r; xl_s = cx_e_s - oy_r; xr_s = cx_e_s + oy_r; end
            2'd3: begin row_s = cy_e_s - ox_r; xl_s = cx_e_s - oy_r; xr_s = cx_e_s + oy_r; end
            default: begin row_s = cy_e_s; xl_s = cx_e_s; xr_s = cx_e_s; end
        endcase
    end

    assign clamp_l_s = xl_s[CW-1] ? ZERO : xl_s;
    assign clamp_r_s = (xr_s > XMAX) ? XMAX : xr_s;
    assign span_ok_s = on_y(row_s) && !(xl_s > XMAX) && !xr_s[CW-1];

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a pass only ends once its last pixel has left the output slot.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  state_nx_s = start ? ((mode == 2'd2) ? S_CLEAR : S_INIT) : S_IDLE;
            S_CLEAR: state_nx_s = pass_exit_s ? S_FIN : S_CLEAR;
            S_INIT:  state_nx_s = fill_s ? S_SPAN : S_OCT;
            S_OCT:   state_nx_s = pass_exit_s ? S_STEP : S_OCT;
            S_SPAN:  state_nx_s = pass_exit_s ? S_STEP : S_SPAN;
            S_STEP:  state_nx_s = loop_ok_s ? (fill_s ? S_SPAN : S_OCT) : S_FIN;
            S_FIN:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Output/control decode: off-screen candidates and rows advance without the slot.
    always_comb begin
        load_s     = 1'b0;
        clr_adv_s  = 1'b0;
        oct_adv_s  = 1'b0;
        span_adv_s = 1'b0;
        pix_x_s    = sx_r[X_W-1:0];
        pix_y_s    = sy_r[Y_W-1:0];
        case (state_r)
            S_CLEAR: begin
                clr_adv_s = slot_free_s && !pass_done_r;
                load_s    = clr_adv_s;
            end
            S_OCT: begin
                oct_adv_s = !pass_done_r && (slot_free_s || !cand_on_s);
                load_s    = oct_adv_s && cand_on_s;
                pix_x_s   = cand_x_s[X_W-1:0];
                pix_y_s   = cand_y_s[Y_W-1:0];
            end
            S_SPAN: begin
                span_adv_s = !pass_done_r && (slot_free_s || !span_act_r);
                load_s     = span_adv_s && span_act_r;
                pix_y_s    = row_s[Y_W-1:0];
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s != S_IDLE) && (state_nx_s != S_FIN);
        done_nx_s = (state_nx_s == S_FIN);
    end

    // Geometry, scan counters and midpoint state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mode_r      <= 2'd0;
            cx_r        <= {X_W{1'b0}};
            cy_r        <= {Y_W{1'b0}};
            rad_r       <= {R_W{1'b0}};
            col_r       <= 3'd0;
            ox_r        <= ZERO;
            oy_r        <= ZERO;
            sx_r        <= ZERO;
            sy_r        <= ZERO;
            crit_r      <= 32'sd0;
            idx_r       <= 3'd0;
            seg_r       <= 2'd0;
            span_act_r  <= 1'b0;
            pass_done_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_r      <= mode;
                        cx_r        <= cx;
                        cy_r        <= cy;
                        rad_r       <= radius;
                        col_r       <= colour_in;
                        sx_r        <= ZERO;
                        sy_r        <= ZERO;
                        pass_done_r <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (clr_adv_s) begin
                        if (sx_r == XMAX) begin
                            sx_r <= ZERO;
                            if (sy_r == YMAX) begin
                                pass_done_r <= 1'b1;
                            end else begin
                                sy_r <= sy_r + ONE;
                            end
                        end else begin
                            sx_r <= sx_r + ONE;
                        end
                    end
                end
                S_INIT: begin
                    ox_r        <= {{(CW-R_W){1'b0}}, rad_r};
                    oy_r        <= ZERO;
                    crit_r      <= 32'sd1 - rad_e_s;
                    idx_r       <= 3'd0;
                    seg_r       <= 2'd0;
                    span_act_r  <= 1'b0;
                    pass_done_r <= 1'b0;
                end
                S_OCT: begin
                    if (oct_adv_s) begin
                        if (idx_r == 3'd7) begin
                            pass_done_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                S_SPAN: begin
                    if (span_adv_s) begin
                        if (!span_act_r && span_ok_s) begin
                            sx_r       <= clamp_l_s;
                            span_act_r <= 1'b1;
                        end else if (span_act_r && (sx_r != clamp_r_s)) begin
                            sx_r <= sx_r + ONE;
                        end else begin
                            span_act_r <= 1'b0;
                            if (seg_r == 2'd3) begin
                                pass_done_r <= 1'b1;
                            end else begin
                                seg_r <= seg_r + 2'd1;
                            end
                        end
                    end
                end
                S_STEP: begin
                    oy_r        <= oy_inc_s;
                    ox_r        <= ox_nx_s;
                    crit_r      <= crit_nx_s;
                    idx_r       <= 3'd0;
                    seg_r       <= 2'd0;
                    span_act_r  <= 1'b0;
                    pass_done_r <= 1'b0;
                end
                default: begin
                    pass_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel slot and status outputs; the pixel holds until consumed.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x_r      <= {X_W{1'b0}};
            y_r      <= {Y_W{1'b0}};
            colour_r <= 3'd0;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (load_s) begin
                x_r      <= pix_x_s;
                y_r      <= pix_y_s;
                colour_r <= col_r;
                plot_r   <= 1'b1;
            end else if (plot_ready) begin
                plot_r <= 1'b0;
            end
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
        end
    end

    assign x      = x_r;
    assign y      = y_r;
    assign colour = colour_r;
    assign plot   = plot_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_circle_engine.sv
// Self-checking bench for circle_engine: directed and random operations compared
// pixel by pixel against a plain-arithmetic midpoint-circle reference.
module tb_circle_engine;
    localparam int SW = 160;
    localparam int SH = 120;

    logic       CLOCK_50 = 1'b0;
    logic       resetn, start, plot_ready;
    logic [1:0] mode;
    logic [7:0] cx;
    logic [6:0] cy, radius;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int errors = 0;
    int checks = 0;
    int exp_total = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    circle_engine #(.X_W(8), .Y_W(7), .R_W(7), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .mode(mode),
        .cx(cx), .cy(cy), .radius(radius), .colour_in(colour_in),
        .plot_ready(plot_ready), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] pk(input int px, input int py, input int pc);
        logic [7:0] xb;
        logic [6:0] yb;
        logic [2:0] cb;
        xb = px[7:0];
        yb = py[6:0];
        cb = pc[2:0];
        return {xb, yb, cb};
    endfunction

    task automatic push_pt(input int px, input int py, input int pc);
        if (px >= 0 && px < SW && py >= 0 && py < SH) exp_q.push_back(pk(px, py, pc));
    endtask

    task automatic push_span(input int row, input int a, input int b, input int pc);
        int lo, hi;
        lo = (a < 0) ? 0 : a;
        hi = (b > SW - 1) ? SW - 1 : b;
        if (row >= 0 && row < SH)
            for (int xx = lo; xx <= hi; xx++) exp_q.push_back(pk(xx, row, pc));
    endtask

    task automatic build_model(input int md, input int ccx, input int ccy, input int r, input int pc);
        int ox, oy, crit;
        exp_q.delete();
        if (md == 2) begin
            for (int yy = 0; yy < SH; yy++)
                for (int xx = 0; xx < SW; xx++) exp_q.push_back(pk(xx, yy, pc));
        end else begin
            ox = r; oy = 0; crit = 1 - r;
            while (oy <= ox) begin
                if (md == 1) begin
                    push_span(ccy + oy, ccx - ox, ccx + ox, pc);
                    push_span(ccy - oy, ccx - ox, ccx + ox, pc);
                    push_span(ccy + ox, ccx - oy, ccx + oy, pc);
                    push_span(ccy - ox, ccx - oy, ccx + oy, pc);
                end else begin
                    push_pt(ccx + ox, ccy + oy, pc);
                    push_pt(ccx + oy, ccy + ox, pc);
                    push_pt(ccx - ox, ccy + oy, pc);
                    push_pt(ccx - oy, ccy + ox, pc);
                    push_pt(ccx - ox, ccy - oy, pc);
                    push_pt(ccx - oy, ccy - ox, pc);
                    push_pt(ccx + ox, ccy - oy, pc);
                    push_pt(ccx + oy, ccy - ox, pc);
                end
                oy++;
                if (crit <= 0) begin
                    crit += 2 * oy + 1;
                end else begin
                    ox--;
                    crit += 2 * (oy - ox) + 1;
                end
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic run_op(input string tag, input int md, input int ccx, input int ccy, input int r,
                          input int pc, input bit hold_first, input int poke_at,
                          input int stop_after, input int budget);
        int cyc, done_cnt, post;
        bit fin, held;
        logic [17:0] snap;
        build_model(md, ccx, ccy, r, pc);
        got_q.delete();
        cyc = 0; done_cnt = 0; post = 0; fin = 1'b0; held = 1'b0;
        @(negedge CLOCK_50);
        mode = md[1:0]; cx = ccx[7:0]; cy = ccy[6:0]; radius = r[6:0]; colour_in = pc[2:0];
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        chk({tag, "_busy_up"}, 32'(busy), 32'd1);
        mode = 2'($urandom_range(0, 3)); cx = 8'($urandom); cy = 7'($urandom);
        radius = 7'($urandom); colour_in = 3'($urandom);
        while (cyc < budget && post < 3) begin
            if (done) begin
                done_cnt++;
                if (!fin) chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                fin = 1'b1;
            end
            if (fin) post++;
            if (hold_first && !held && plot) begin
                held = 1'b1;
                snap = {x, y, colour};
                plot_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLOCK_50);
                    chk({tag, "_hold_plot"}, 32'(plot), 32'd1);
                    chk({tag, "_hold_pix"}, 32'({x, y, colour}), 32'(snap));
                end
            end
            plot_ready = ($urandom_range(0, 3) != 0);
            start = (cyc == poke_at);
            if (plot && plot_ready) begin
                got_q.push_back({x, y, colour});
                if (exp_q.size() > 0)
                    chk({tag, "_pix"}, 32'({x, y, colour}), 32'(exp_q.pop_front()));
                else
                    chk({tag, "_extra_pix"}, 32'(got_q.size()), 32'(exp_total));
            end
            if (stop_after > 0 && int'(got_q.size()) == stop_after) begin
                plot_ready = 1'b0;
                start = 1'b0;
                resetn = 1'b0;
                #1;
                chk({tag, "_rst_plot"}, 32'(plot), 32'd0);
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_done"}, 32'(done), 32'd0);
                @(negedge CLOCK_50);
                resetn = 1'b1;
                plot_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLOCK_50);
                    chk({tag, "_idle_plot"}, 32'(plot), 32'd0);
                end
                plot_ready = 1'b0;
                return;
            end
            @(negedge CLOCK_50);
            cyc++;
        end
        start = 1'b0;
        plot_ready = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_total));
    endtask

    initial begin
        int bad, found, md;
        resetn = 1'b0; start = 1'b0; mode = 2'd0; cx = 8'd0; cy = 7'd0;
        radius = 7'd0; colour_in = 3'd0; plot_ready = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;

        run_op("oct_r10", 0, 80, 60, 10, 5, 1'b0, -1, 0, 5000);
        chk("oct_r10_total", 32'(got_q.size()), 32'd64);
        chk("oct_r10_first", 32'(got_q[0]), 32'(pk(90, 60, 5)));
        chk("oct_r10_second", 32'(got_q[1]), 32'(pk(80, 70, 5)));

        run_op("oct_r0", 0, 80, 60, 0, 2, 1'b0, -1, 0, 2000);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== pk(80, 60, 2)) bad++;
        chk("oct_r0_total", 32'(got_q.size()), 32'd8);
        chk("oct_r0_centre", 32'(bad), 32'd0);

        run_op("clip", 0, 2, 2, 5, 7, 1'b0, -1, 0, 2000);
        bad = 0; found = 0;
        foreach (got_q[i]) begin
            if (got_q[i][17:10] >= 8'd160 || got_q[i][9:3] >= 7'd120) bad++;
            if (got_q[i] === pk(7, 2, 7)) found++;
        end
        chk("clip_offscreen", 32'(bad), 32'd0);
        chk("clip_has_7_2", 32'(found > 0), 32'd1);

        run_op("bp", 0, 40, 30, 6, 6, 1'b1, -1, 0, 3000);

        run_op("clear", 2, 0, 0, 0, 0, 1'b0, 1000, 0, 40000);
        chk("clear_first", 32'(got_q[0]), 32'(pk(0, 0, 0)));
        chk("clear_last", 32'(got_q[got_q.size() - 1]), 32'(pk(159, 119, 0)));

        run_op("fill_rst", 1, 80, 60, 3, 4, 1'b0, -1, 3, 2000);
        run_op("fill_r3", 1, 80, 60, 3, 4, 1'b0, -1, 0, 3000);
        chk("fill_r3_first", 32'(got_q[0]), 32'(pk(77, 60, 4)));

        run_op("fill_r0", 1, 80, 60, 0, 1, 1'b0, -1, 0, 2000);

        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0: md = 0;
                1: md = 1;
                default: md = 3;
            endcase
            run_op($sformatf("rnd%0d", i), md, int'($urandom_range(0, 200)),
                   int'($urandom_range(0, 127)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 7)), 1'b0, -1, 0, 20000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
